// File: rtl/sled_pkg.sv
// sled_pkg: shared segment constants and hex-to-segment encoding for the multiplexed display driver
package sled_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [15:0][7:0] HEX_TAB = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dp);
    return {~dp, HEX_TAB[nib][6:0]};
  endfunction
endpackage

// File: rtl/sled_if.sv
// sled_if: datapath-side digit inputs and board-side segment/digit outputs of sled_scan
interface sled_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] blank;
  logic load;
  logic [7:0] LED7S;
  logic [DIGITS-1:0] dig;
  logic frame_start;
  modport master (output value, dp, blank, load, input LED7S, dig, frame_start);
  modport slave (input value, dp, blank, load, output LED7S, dig, frame_start);
endinterface

// File: rtl/sled_hex_dec.sv
// sled_hex_dec: nibble plus decimal point to active-low 7-segment code
module sled_hex_dec
  import sled_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  always_comb seg = seg_of(nib, dp);
endmodule

// File: rtl/sled_scan.sv
// sled_scan: N-digit multiplexed 7-seg driver with blanking and frame-synchronous update; SLED_LEADING_ZERO_BLANK_EN suppresses leading zeros
module sled_scan
  import sled_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input logic   clk,
  input logic   rst,
  sled_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } frame_t;
  logic [PW-1:0] pres_q, pres_d;
  logic [IW-1:0] idx_q, idx_d;
  frame_t shadow_q, shadow_d, display_q, display_d, in_frame;
  logic pending_q, pending_d;
  logic [7:0] led_q, led_d, dec_seg;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic fs_q, fs_d;
  logic tick, boundary, blanked, lz_on, dp_bit;
  logic [3:0] nib;
  assign in_frame = {bus.value, bus.dp, bus.blank};
  assign tick     = int'(pres_q) == SCAN_DIV - 1;
  assign boundary = tick && int'(idx_q) == DIGITS - 1;
  assign blanked  = int'(pres_q) < BLANK_CYC;
  assign nib      = display_q.value[{idx_q, 2'b00} +: 4];
  assign dp_bit   = display_q.dp[idx_q];
  sled_hex_dec u_dec (.nib(nib), .dp(dp_bit), .seg(dec_seg));
`ifdef SLED_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  always_comb begin
    logic z;
    z  = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z     = z && display_q.value[4*i +: 4] == 4'h0;
      lz[i] = z;
    end
  end
  assign lz_on = lz[idx_q];
`else
  assign lz_on = 1'b0;
`endif
  always_comb begin
    pres_d    = tick ? '0 : pres_q + 1'b1;
    idx_d     = !tick ? idx_q : int'(idx_q) == DIGITS - 1 ? '0 : idx_q + 1'b1;
    shadow_d  = bus.load ? in_frame : shadow_q;
    pending_d = bus.load ? !boundary : boundary ? 1'b0 : pending_q;
    display_d = bus.load && boundary ? in_frame : boundary && pending_q ? shadow_q : display_q;
    dig_d     = blanked ? '1 : ~(DIGITS'(1) << idx_q);
    led_d     = blanked || display_q.blank[idx_q] ? SEG_OFF : lz_on ? {~dp_bit, 7'h7F} : dec_seg;
    fs_d      = pres_q == '0 && idx_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pres_q    <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      led_q     <= SEG_OFF;
      dig_q     <= '1;
      fs_q      <= 1'b0;
    end else begin
      pres_q    <= pres_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      dig_q     <= dig_d;
      fs_q      <= fs_d;
    end
  end
  assign bus.LED7S       = led_q;
  assign bus.dig         = dig_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_sled_scan.sv
// tb_sled_scan: directed plus randomized bench checking sled_scan against a frame-level reference model
module tb_sled_scan;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = D * SD;
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef struct {
    int          cyc;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
  } load_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int s, checks, passed, fails;
  load_t loads[$];
  sled_if #(.DIGITS(D)) bus ();
  sled_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void expect_at(input int st, output logic [7:0] led, output logic [3:0] dg, output logic fs);
    int pos, slot, fr;
    logic [15:0] v;
    logic [3:0] d, b, n;
    logic sup;
    pos = st % SD;
    slot = (st / SD) % D;
    fr = st / FR;
    v = '0;
    d = '0;
    b = '0;
    foreach (loads[k])
      if (loads[k].cyc < fr * FR) begin
        v = loads[k].v;
        d = loads[k].d;
        b = loads[k].b;
      end
    fs = pos == 0 && slot == 0;
    n = v[4*slot +: 4];
    sup = 1'b0;
`ifdef SLED_LEADING_ZERO_BLANK_EN
    sup = slot > 0 && (v >> (4 * slot)) == 16'h0;
`endif
    dg = pos < BC ? 4'hF : ~(4'h1 << slot);
    led = pos < BC || b[slot] ? 8'hFF : sup ? {~d[slot], 7'h7F} : {~d[slot], HEX[n][6:0]};
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s at state %0d: got %h expected %h", tag, s, got, exp);
    end
  endtask
  task automatic run(input int n);
    logic [7:0] el;
    logic [3:0] ed;
    logic ef, r;
    repeat (n) begin
      r = rst;
      if (!r && bus.load) loads.push_back('{s, bus.value, bus.dp, bus.blank});
      @(posedge clk);
      #1;
      if (r) begin
        el = 8'hFF;
        ed = 4'hF;
        ef = 1'b0;
        s = 0;
        loads.delete();
      end else begin
        expect_at(s, el, ed, ef);
        s++;
      end
      check("LED7S", bus.LED7S, el);
      check("dig", 8'(bus.dig), 8'(ed));
      check("frame_start", 8'(bus.frame_start), 8'(ef));
    end
  endtask
  task automatic run_to(input int ph);
    while (s % FR != ph) run(1);
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus.value = v;
    bus.dp = d;
    bus.blank = b;
    bus.load = 1'b1;
    run(1);
    bus.load = 1'b0;
    bus.value = 16'($urandom);
    bus.dp = 4'($urandom);
    bus.blank = 4'($urandom);
  endtask
  initial begin
    checks = 0;
    passed = 0;
    fails = 0;
    s = 0;
    bus.value = '0;
    bus.dp = '0;
    bus.blank = '0;
    bus.load = 1'b0;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FR);
    do_load(16'h3210, 4'b0100, 4'h0);
    run(2 * FR);
    do_load(16'h7654, 4'b1001, 4'h0);
    run(2 * FR);
    do_load(16'hBA98, 4'b0000, 4'h0);
    run(2 * FR);
    do_load(16'hFEDC, 4'b1111, 4'h0);
    run(2 * FR);
    do_load(16'h1234, 4'h0, 4'h0);
    run_to(0);
    run_to(6);
    do_load(16'hABCD, 4'h0, 4'h0);
    run(2 * FR);
    run_to(FR - 1);
    do_load(16'h5A5A, 4'b0010, 4'h0);
    run(FR);
    do_load(16'h9876, 4'h0, 4'b0010);
    run(2 * FR);
    repeat (12) begin
      run($urandom_range(0, 20));
      do_load(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
    end
    run(2 * FR);
    run_to(2 * SD + 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(FR + 2);
    do_load(16'h0050, 4'h0, 4'h0);
    run(2 * FR);
    do_load(16'h0000, 4'b0100, 4'h0);
    run(2 * FR);
    do_load(16'h0000, 4'h0, 4'h0);
    run(2 * FR);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sled_scan.md
Name: sled_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Generalises the single-digit hex decoder:
  - parametrised digit count;
  - registered scan sequencer with a prescaler;
  - anti-ghosting blanking window;
  - tear-free frame-synchronous value update;
  - per-digit decimal point and blank controls.
- Sits between the user datapath (counters, ALU results) and the board's shared segment bus and digit-enable lines.

Parameters:
- DIGITS, 8, number of multiplexed digits (1..16).
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYC, 500, cycles at the start of each slot with all digits off (0 .. SCAN_DIV-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 is the rightmost.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- blank  in  DIGITS  per-digit blank, 1 = digit dark.
- load  in  1  one-cycle strobe; captures value/dp/blank into the shadow register.
- LED7S  out  8  segments, active-low; bit7 = dp, bits6..0 = g..a.
- dig  out  DIGITS  digit enables, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pres=0, idx=0.
  - shadow, display and pending cleared.
  - LED7S=8'hFF, dig=all ones, frame_start=0.
- Prescaler `pres`:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (pres==SCAN_DIV-1).
- Digit index `idx`:
  - Increments on tick.
  - Wraps from DIGITS-1 to 0.
  - With DIGITS=1, idx stays 0.
- Frame boundary = tick while idx==DIGITS-1.
- Shadow and display update:
  - load: shadow <= {value, dp, blank}; pending <= 1.
  - At a frame boundary with pending=1: display <= shadow; pending <= 0.
  - load coinciding with a boundary: the new inputs go to both shadow and display; pending <= 0.
  - load is ignored during rst.
- Outputs are registered, one cycle after the state they reflect:
  - If pres < BLANK_CYC: dig = all ones, LED7S = 8'hFF.
  - Else: dig = ~(1<<idx).
    - LED7S[6:0] = hex code of display nibble idx.
    - LED7S[7] = ~display.dp[idx].
    - If display.blank[idx]=1, LED7S = 8'hFF while dig is still driven, so slot timing is unchanged.
  - frame_start = 1 in the cycle after idx becomes 0 via wrap, and once 1 cycle after reset release.
- Hex codes (active-low {dp=1, g..a}):
  - 0..7: C0 F9 A4 B0 99 92 82 F8.
  - 8..F: 80 90 88 83 C6 A1 86 8E.
- Exactly one digit is enabled at any time outside blanking; never more than one.
- Frame period = DIGITS*SCAN_DIV cycles.
- Reset mid-frame aborts immediately; the scan restarts at digit 0 with blanking.

Optional Feature:
- Macro SLED_LEADING_ZERO_BLANK_EN.
- Defined: while scanning, display nibbles equal to 0 are forced dark (LED7S=8'hFF), provided all higher-index nibbles are also 0. Digit 0 is never suppressed. dp still overrides: a suppressed digit with dp=1 shows only the dp (8'h7F).
- Undefined: all nibbles are decoded literally.

Decomposition:
- Package sled_pkg holds:
  - SEG_OFF = 8'hFF;
  - the 16-entry hex-to-segment constant table;
  - a function seg_of(nibble, dp).
- One combinational sub-module, sled_hex_dec (nibble + dp -> 8-bit active-low code).
- Prescaler, index, shadow/display and output registers stay in sled_scan.

Test Plan:
- Reset check, DIGITS=4, SCAN_DIV=4, BLANK_CYC=1:
  - Hold rst 3 cycles -> LED7S=8'hFF, dig=4'hF, frame_start=0.
  - After release, frame_start pulses once.
  - dig sequence per slot: F,E,E,E then F,D,D,D then F,B,B,B then F,7,7,7, repeating.
- Decode sweep: load value=16'h3210, dp=4'b0100, blank=0.
  - After the next frame boundary, slots show C0, F9, 24 (A4 with dp lit), B0.
  - Repeat for all 16 nibbles -> table codes.
- Tear-free update: load 16'hABCD mid-frame while 16'h1234 is shown.
  - Remaining slots still show 4,3,2,1.
  - 16'hABCD appears starting at the next digit-0 slot.
- Simultaneous load and frame boundary: assert load on the tick with idx=3 -> the new value is shown in the immediately following digit-0 slot.
- Blank and reset mid-operation:
  - blank=4'b0010 -> digit 1's slot has dig=D but LED7S=FF.
  - Assert rst in the middle of digit 2's slot -> next cycle outputs FF/F; the scan restarts at digit 0.
- With SLED_LEADING_ZERO_BLANK_EN, value=16'h0050:
  - Digits 3 and 2 are dark.
  - Digit 1 shows 92.
  - Digit 0 shows C0.
  - value=16'h0000 -> only digit 0 shows C0.
